ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 115 +++++++++++
 tb/tb_ifetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ifetch_unit
// Brief    : Instruction fetch stage with stall/hold buffering, branch redirect
//            and sticky misaligned-target flag, front-ending a 1-cycle ROM.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [13:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        misaligned_err
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_fpc;
    logic [31:0] w_fpc_next;
    logic [31:0] r_pc_d;
    logic [31:0] w_pc_d_next;
    logic [31:0] r_hold;
    logic [31:0] w_hold_next;
    logic        r_err;
    logic        w_err_next;
    logic [31:0] w_fpc_plus4;
    logic [31:0] w_target_aligned;

    assign w_fpc_plus4      = r_fpc + 32'd4;
    assign w_target_aligned = {branch_target[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FILL;
            r_fpc   <= RESET_PC;
            r_pc_d  <= RESET_PC;
            r_hold  <= NOP_INSTR;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_fpc   <= w_fpc_next;
            r_pc_d  <= w_pc_d_next;
            r_hold  <= w_hold_next;
            r_err   <= w_err_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fpc_next   = r_fpc;
        w_pc_d_next  = r_pc_d;
        w_hold_next  = r_hold;
        w_err_next   = r_err;
        instr        = NOP_INSTR;
        instr_valid  = 1'b0;

        case (r_state)
            RUN: begin
                instr       = imem_data;
                instr_valid = 1'b1;
            end
            HOLD: begin
                instr       = r_hold;
                instr_valid = 1'b1;
            end
            default: begin
                instr       = NOP_INSTR;
                instr_valid = 1'b0;
            end
        endcase

        if (branch_taken) begin
            // Redirect beats stall; the ROM word now in flight is for the old path.
            w_fpc_next   = w_target_aligned;
            w_state_next = FILL;
            w_hold_next  = NOP_INSTR;
            if (branch_target[1:0] != 2'b00) begin
                w_err_next = 1'b1;
            end
        end else if (!stall) begin
            w_pc_d_next  = r_fpc;
            w_fpc_next   = w_fpc_plus4;
            w_state_next = RUN;
        end else if (r_state == RUN) begin
            // ROM output moves on to fpc next cycle, so park the current word.
            w_hold_next  = imem_data;
            w_state_next = HOLD;
        end else if (r_state != HOLD) begin
            w_state_next = FILL;
        end
    end

    assign imem_addr      = r_fpc[15:2];
    assign pc             = r_pc_d;
    assign pc_plus4       = r_pc_d + 32'd4;
    assign misaligned_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_ifetch_unit
// Brief    : Self-checking bench for ifetch_unit against a program-order model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_ifetch_unit;

    localparam logic [31:0] c_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [13:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        misaligned_err;

    logic [31:0] rom_mem [0:16383];

    int n_cmp = 0;
    int n_err = 0;

    // Model: the next program-order address to present, and what is shown now.
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_next;
    logic        m_err;

    ifetch_unit #(
        .RESET_PC  (c_RESET_PC),
        .NOP_INSTR (c_NOP_INSTR)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .instr          (instr),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .instr_valid    (instr_valid),
        .misaligned_err (misaligned_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= rom_mem[imem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_valid = 1'b0;
            m_pc    = c_RESET_PC;
            m_next  = c_RESET_PC;
            m_err   = 1'b0;
        end else if (branch_taken) begin
            m_valid = 1'b0;
            m_next  = branch_target & 32'hFFFF_FFFC;
            if (branch_target[1:0] != 2'b00) m_err = 1'b1;
        end else if (!stall) begin
            m_valid = 1'b1;
            m_pc    = m_next;
            m_next  = m_next + 32'd4;
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_instr;
        exp_instr = m_valid ? rom_mem[m_pc[15:2]] : c_NOP_INSTR;
        check("valid", {31'd0, instr_valid}, {31'd0, m_valid});
        check("instr", instr, exp_instr);
        if (m_valid) begin
            check("pc", pc, m_pc);
            check("pc_plus4", pc_plus4, m_pc + 32'd4);
        end
        check("imem_addr", {18'd0, imem_addr}, {18'd0, m_next[15:2]});
        check("misaligned_err", {31'd0, misaligned_err}, {31'd0, m_err});
    endtask

    task automatic do_step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_in(input logic r, input logic s, input logic b, input logic [31:0] t);
        reset         = r;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
    endtask

    task automatic do_reset();
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        do_step();
        check("rst_pc", pc, c_RESET_PC);
        check("rst_pc_plus4", pc_plus4, c_RESET_PC + 32'd4);
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) rom_mem[i] = 32'h1000_0000 + i;
        m_valid = 1'b0;
        m_pc    = c_RESET_PC;
        m_next  = c_RESET_PC;
        m_err   = 1'b0;

        // Reset release and sequential fetch
        set_in(1'b1, 1'b1, 1'b1, 32'h46);
        do_step();
        check("rst_valid_override", {31'd0, instr_valid}, 32'd0);
        check("rst_err_override", {31'd0, misaligned_err}, 32'd0);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            do_step();
            check("seq_pc", pc, 32'(4 * k));
            check("seq_instr", instr, 32'h1000_0000 + 32'(k));
        end

        // Stall while pc=8
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            do_step();
            check("stall_pc", pc, 32'h8);
            check("stall_instr", instr, 32'h1000_0002);
        end
        stall = 1'b0;
        do_step();
        check("release_pc", pc, 32'hC);
        check("release_instr", instr, 32'h1000_0003);

        // Redirect while pc=4
        do_reset();
        do_step();
        do_step();
        set_in(1'b0, 1'b0, 1'b1, 32'h40);
        do_step();
        check("br_bubble", {31'd0, instr_valid}, 32'd0);
        branch_taken = 1'b0;
        do_step();
        check("br_pc", pc, 32'h40);
        check("br_instr", instr, 32'h1000_0010);

        // Redirect with stall in HOLD
        stall = 1'b1;
        do_step();
        set_in(1'b0, 1'b1, 1'b1, 32'h20);
        do_step();
        check("hold_br_bubble", {31'd0, instr_valid}, 32'd0);
        branch_taken = 1'b0;
        do_step();
        stall = 1'b0;
        do_step();
        check("hold_br_pc", pc, 32'h20);

        // Misaligned target
        set_in(1'b0, 1'b0, 1'b1, 32'h46);
        do_step();
        check("mis_flag", {31'd0, misaligned_err}, 32'd1);
        branch_taken = 1'b0;
        do_step();
        check("mis_pc", pc, 32'h44);
        do_step();
        check("mis_sticky", {31'd0, misaligned_err}, 32'd1);
        do_reset();
        check("mis_cleared", {31'd0, misaligned_err}, 32'd0);

        // Wrap at top of address space
        set_in(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        do_step();
        branch_taken = 1'b0;
        do_step();
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", pc_plus4, 32'h0);
        do_step();
        check("wrap_next_pc", pc, 32'h0);

        // Randomized phase with random ROM contents
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 16384; i++) rom_mem[i] = $urandom;
        do_step();
        for (int n = 0; n < 4000; n++) begin
            reset        = ($urandom_range(0, 99) == 0);
            stall        = ($urandom_range(0, 2) == 0);
            branch_taken = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: branch_target = $urandom;
                1: branch_target = 32'($urandom_range(0, 255)) << 2;
                2: branch_target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: branch_target = $urandom & 32'h0000_FFFF;
            endcase
            do_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
